// File: rtl/rvee_fetch.sv
// Instruction fetch stage: issues PCs to instruction memory, buffers in-order
// responses in a small circular slot buffer and hands them to decode.
module rvee_fetch #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            pc_ready,
    input  logic            jmp,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            dec_valid,
    output logic [31:0]     dec_insn,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_fault,
    input  logic            dec_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][XLEN-1:0] slot_pc;
    logic [DEPTH-1:0][31:0]     slot_insn;
    logic [DEPTH-1:0]           slot_err;
    logic [DEPTH-1:0]           slot_filled;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fill_idx;
    logic [CW-1:0] used;
    logic [CW-1:0] pend;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_flush;
    logic [CW:0]   occ;
    logic [CW:0]   outstanding;

    logic credit;
    logic issue;
    logic rsp_store;
    logic rsp_drop;
    logic retire;

    // Credits count both live slots and responses still owed to a flushed stream.
    always_comb begin
        occ    = (CW+1)'(used) + (CW+1)'(drop_cnt);
        credit = occ < (CW+1)'(DEPTH);
    end

    assign imem_req_valid = pc_valid & credit & ~jmp;
    assign imem_req_addr  = pc;
    assign pc_ready       = imem_req_valid & imem_req_ready;
    assign issue          = pc_ready;

    assign rsp_store = imem_rsp_valid & ~jmp & (drop_cnt == '0) & (pend != '0);
    assign rsp_drop  = imem_rsp_valid & ~jmp & (drop_cnt != '0);

    // Unfilled slots are the youngest pend entries, so the oldest sits pend behind tail.
    assign fill_idx = tail - PW'(pend);

    assign dec_valid = slot_filled[head] & (used != '0) & ~jmp;
    assign retire    = dec_valid & dec_ready;
    assign dec_insn  = slot_insn[head];
    assign dec_pc    = slot_pc[head];
    assign dec_fault = slot_err[head];

    // On flush every outstanding request becomes a response to discard,
    // except one arriving in the flush cycle itself.
    always_comb begin
        outstanding = (CW+1)'(pend) + (CW+1)'(drop_cnt);
        if (imem_rsp_valid && (outstanding != '0)) begin
            outstanding = outstanding - (CW+1)'(1);
        end
        drop_flush = CW'(outstanding);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            used        <= '0;
            pend        <= '0;
            drop_cnt    <= '0;
            slot_filled <= '0;
            slot_err    <= '0;
            slot_pc     <= '0;
            slot_insn   <= '0;
        end else if (jmp) begin
            head        <= tail;
            used        <= '0;
            pend        <= '0;
            drop_cnt    <= drop_flush;
            slot_filled <= '0;
        end else begin
            if (issue) begin
                slot_pc[tail]     <= pc;
                slot_filled[tail] <= 1'b0;
                tail              <= tail + PW'(1);
            end
            if (rsp_store) begin
                slot_insn[fill_idx]   <= imem_rsp_data;
                slot_err[fill_idx]    <= imem_rsp_err;
                slot_filled[fill_idx] <= 1'b1;
            end
            if (retire) begin
                slot_filled[head] <= 1'b0;
                head              <= head + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            used <= used + CW'(issue) - CW'(retire);
            pend <= pend + CW'(issue) - CW'(rsp_store);
        end
    end

endmodule
